// File: rtl/axi_tb_pkg.sv
// Shared AXI write-channel types and response codes for the W-channel responder.
package axi_tb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // IDs are carried at a fixed maximum width so the types stay parameter-free
  localparam int unsigned ID_MAX_W = 16;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [3:0]          len;
  } aw_entry_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [1:0]          resp;
  } b_entry_t;

endpackage

// File: rtl/axi_sync_fifo.sv
// Synchronous FIFO with occupancy count; storage is unreset, head is combinational.
module axi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   srst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (srst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axi_slv_wch_responder.sv
// AXI slave write-channel responder: queues AW, checks W bursts against AW, issues B.
module axi_slv_wch_responder
  import axi_tb_pkg::*;
#(
  parameter int unsigned AXI_ID_W        = 4,
  parameter int unsigned AXI_DATA_W      = 32,
  parameter int unsigned SLV_OSTDREQ_NUM = 4,
  parameter int unsigned B_FIFO_DEPTH    = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [AXI_ID_W-1:0]     s_awid,
  input  logic [3:0]              s_awlen,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [AXI_ID_W-1:0]     s_wid,
  input  logic [AXI_DATA_W-1:0]   s_wdata,
  input  logic [AXI_DATA_W/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [AXI_ID_W-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic [7:0]              err_cnt
);

  aw_entry_t aw_in, aw_head;
  b_entry_t  b_in, b_head;
  logic [$clog2(SLV_OSTDREQ_NUM):0] aw_count;
  logic [$clog2(B_FIFO_DEPTH):0]    b_count;
  logic aw_full, aw_empty, b_full, b_empty;
  logic aw_push, w_hs, b_pop;
  logic is_final, beat_err, term;
  logic [3:0] beat_cnt;
  logic       sticky_err;
  logic       unused_sink;

  assign aw_in     = {ID_MAX_W'(s_awid), s_awlen};
  assign s_awready = ~aw_full;
  assign aw_push   = s_awvalid & s_awready;

  // W is only accepted against an already-registered AW head, never a same-cycle bypass
  assign s_wready = ~aw_empty & ~b_full;
  assign w_hs     = s_wvalid & s_wready;
  assign is_final = (beat_cnt == aw_head.len);
  assign beat_err = (s_wid != AXI_ID_W'(aw_head.id)) | (s_wlast != is_final);
  assign term     = w_hs & (s_wlast | is_final);

  assign b_in.id   = aw_head.id;
  assign b_in.resp = (sticky_err | beat_err) ? RESP_SLVERR : RESP_OKAY;

  assign s_bvalid = ~b_empty;
  assign b_pop    = s_bvalid & s_bready;
  assign s_bid    = b_empty ? '0 : AXI_ID_W'(b_head.id);
  assign s_bresp  = b_empty ? '0 : b_head.resp;

  assign unused_sink = ^{aw_count, b_count, s_wdata, s_wstrb};

  axi_sync_fifo #(
    .WIDTH ($bits(aw_entry_t)),
    .DEPTH (SLV_OSTDREQ_NUM)
  ) u_aw_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .srst  (srst),
    .push  (aw_push),
    .pop   (term),
    .wdata (aw_in),
    .rdata (aw_head),
    .count (aw_count),
    .full  (aw_full),
    .empty (aw_empty)
  );

  axi_sync_fifo #(
    .WIDTH ($bits(b_entry_t)),
    .DEPTH (B_FIFO_DEPTH)
  ) u_b_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .srst  (srst),
    .push  (term),
    .pop   (b_pop),
    .wdata (b_in),
    .rdata (b_head),
    .count (b_count),
    .full  (b_full),
    .empty (b_empty)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt   <= '0;
      sticky_err <= 1'b0;
      err_cnt    <= '0;
    end else if (srst) begin
      beat_cnt   <= '0;
      sticky_err <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (term) begin
        beat_cnt   <= '0;
        sticky_err <= 1'b0;
        if (b_in.resp == RESP_SLVERR && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (beat_err) sticky_err <= 1'b1;
      end
    end
  end

endmodule
